jtcop_bus_resp: RTL and testbench
=================================

Name: jtcop_bus_resp

Overview:
- Bus-cycle responder for the main 68000 in the jtcop cores.
- Consumes the chip selects produced by the main address decoder, plus completion strobes from the slow targets (SDRAM ROM, HuC6280 shared RAM).
- Generates DTACKn with per-target wait states, a watchdog timeout and unmapped-access flagging.
- Sits between the decoder and the CPU, closing every bus cycle the decoder opens.

Parameters:
- RAM_WAIT, 0: extra cen ticks before DTACKn for sysram/palette/object/display RAM.
- IO_WAIT, 1: extra cen ticks for I/O, protection and unmapped cycles.
- TOUT, 255: clk cycles a cycle may stay in any wait state before forced DTACKn; 8-bit counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cen  in  1  68000 clock enable, one-clk pulse per CPU clock
- ASn  in  1  CPU address strobe
- UDSn  in  1  upper data strobe
- LDSn  in  1  lower data strobe
- rom_cs  in  1  decoder ROM select
- rom_ok  in  1  SDRAM data valid for current ROM address
- ram_cs  in  1  OR of sysram/pal/obj/disp selects
- io_cs  in  1  OR of read_cs/snreq/prisel/nexrm0/mixpsel selects
- huc_cs  in  1  HuC6280 shared-RAM select
- huc_ack  in  1  HuC side grants access, level
- DTACKn  out  1  data acknowledge to CPU
- busy  out  1  high while a cycle is in a wait state
- tout  out  1  one-clk pulse on watchdog expiry
- unmapped  out  1  one-clk pulse when a cycle starts with no select active

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE, DTACKn=1, busy=0, tout=0, unmapped=0, wait and timeout counters 0, ok_l=0. Reset overrides every state, including mid-cycle.
- Cycle start: state IDLE, cen=1, ASn=0 and (UDSn=0 or LDSn=0). Selects are sampled once at start.
- Target priority at start: rom_cs > huc_cs > ram_cs > io_cs > none.
- Next state by target:
  - ROM -> WAIT_ROM.
  - HuC -> WAIT_HUC.
  - RAM -> WAIT_FIX, counter=RAM_WAIT.
  - IO -> WAIT_FIX, counter=IO_WAIT.
  - none -> WAIT_FIX, counter=IO_WAIT, plus unmapped=1 for that single clk.
- All wait states: busy=1; timeout counter is cleared at start and increments every clk.
- WAIT_FIX: on each cen, if counter==0 then DTACKn<=0 and go to ACK, else counter decrements. With RAM_WAIT=0, DTACKn falls on the first cen after the start cen.
- WAIT_ROM: ok_l<=rom_ok every clk. On cen with rom_ok=1 and ok_l=1, DTACKn<=0 and go to ACK. Requiring two consecutive clks of rom_ok rejects a stale rom_ok left over from the previous address.
- WAIT_HUC: on cen with huc_ack=1, DTACKn<=0 and go to ACK.
- Watchdog: in any wait state, when the timeout counter reaches TOUT:
  - DTACKn<=0, go to ACK, tout=1 for one clk.
  - Takes precedence over a same-clk normal ack; only one tout pulse is issued.
- ACK: busy=0, DTACKn held 0 until ASn=1. On the first clk with ASn=1, DTACKn<=1 and go to IDLE, independent of cen.
- Back-to-back cycles: a new start is only accepted from IDLE, so at least one clk separates DTACKn rising from the next start. A cycle with ASn already low on re-entry to IDLE starts at the next cen.
- Abort: ASn=1 while in any wait state (e.g. CPU reset or bus error path) -> IDLE, DTACKn=1, busy=0, no tout pulse, counters cleared.
- Selects changing mid-cycle are ignored because the target is latched at start.
- Data strobes deasserting before ASn has no effect; only ASn ends a cycle.
- rom_ok/huc_ack are not checked outside their own wait state.
- TOUT=0 is illegal; behaviour is undefined.

Test Plan:
- RAM read, RAM_WAIT=0: ASn/LDSn low with ram_cs at cen#0 -> busy at clk+1, DTACKn=0 right after cen#1; ASn high -> DTACKn=1 next clk, state IDLE.
- IO write, IO_WAIT=1: io_cs cycle -> DTACKn low after cen#2, never earlier; unmapped stays 0.
- ROM with stale ok: rom_ok high only 1 clk after start, then low 20 clks, then high -> DTACKn only after 2 consecutive rom_ok clks and a cen; no ack on the stale pulse.
- Priority: rom_cs and ram_cs both high at start, rom_ok held low 10 clks -> response waits for rom_ok (ROM path), not RAM_WAIT.
- HuC starvation: huc_cs, huc_ack=0, TOUT=255 -> exactly 1 tout pulse at the 255th clk, DTACKn low, released on ASn high.
- Unmapped plus reset mid-cycle: no selects -> unmapped pulse of 1 clk, DTACKn after IO_WAIT. Repeat, asserting rst during WAIT_FIX -> next clk DTACKn=1, busy=0, IDLE.

Source files
------------

// File: rtl/jtcop_bus_resp.sv
// Bus-cycle responder for the jtcop main 68000: closes every cycle the
// address decoder opens, with per-target wait states, a watchdog and
// unmapped-access flagging.
module jtcop_bus_resp #(
    parameter int unsigned RAM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 1,
    parameter int unsigned TOUT     = 255
)(
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic ASn,
    input  logic UDSn,
    input  logic LDSn,
    input  logic rom_cs,
    input  logic rom_ok,
    input  logic ram_cs,
    input  logic io_cs,
    input  logic huc_cs,
    input  logic huc_ack,
    output logic DTACKn,
    output logic busy,
    output logic tout,
    output logic unmapped
);

    localparam int unsigned WCW = 8;
    localparam int unsigned TCW = 8;

    // Watchdog fires on the clk where the counter steps onto TOUT
    localparam logic [TCW-1:0] TOUT_LAST = TCW'(TOUT - 1);
    localparam logic [WCW-1:0] RAM_LOAD  = WCW'(RAM_WAIT);
    localparam logic [WCW-1:0] IO_LOAD   = WCW'(IO_WAIT);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FIX,
        WAIT_ROM,
        WAIT_HUC,
        ACK
    } state_t;

    state_t         st, st_nx;
    logic [WCW-1:0] wcnt, wcnt_nx;
    logic [TCW-1:0] tcnt, tcnt_nx;
    logic           ok_l, ok_l_nx;
    logic           dtackn_nx, busy_nx, tout_nx, unmapped_nx;
    logic           start_c, in_wait_c, dog_c, ack_c;

    // Cycle start, wait-state and completion qualifiers
    always_comb begin
        start_c   = (st == IDLE) && cen && !ASn && (!UDSn || !LDSn);
        in_wait_c = (st == WAIT_FIX) || (st == WAIT_ROM) || (st == WAIT_HUC);
        dog_c     = in_wait_c && (tcnt == TOUT_LAST);
        ack_c     = cen && (((st == WAIT_FIX) && (wcnt == '0))            ||
                            ((st == WAIT_ROM) && rom_ok && ok_l)          ||
                            ((st == WAIT_HUC) && huc_ack));
    end

    // Next-state and next-output logic
    always_comb begin
        st_nx       = st;
        wcnt_nx     = wcnt;
        tcnt_nx     = '0;
        ok_l_nx     = 1'b0;
        dtackn_nx   = DTACKn;
        tout_nx     = 1'b0;
        unmapped_nx = 1'b0;

        case (st)
            IDLE: begin
                dtackn_nx = 1'b1;
                wcnt_nx   = '0;
                if (start_c) begin
                    // Target is latched here; later select changes are ignored
                    if (rom_cs) begin
                        st_nx = WAIT_ROM;
                    end else if (huc_cs) begin
                        st_nx = WAIT_HUC;
                    end else if (ram_cs) begin
                        st_nx   = WAIT_FIX;
                        wcnt_nx = RAM_LOAD;
                    end else if (io_cs) begin
                        st_nx   = WAIT_FIX;
                        wcnt_nx = IO_LOAD;
                    end else begin
                        st_nx       = WAIT_FIX;
                        wcnt_nx     = IO_LOAD;
                        unmapped_nx = 1'b1;
                    end
                end
            end

            WAIT_FIX, WAIT_ROM, WAIT_HUC: begin
                tcnt_nx = tcnt + TCW'(1);
                // Two consecutive rom_ok clks are needed to reject stale data
                if (st == WAIT_ROM) ok_l_nx = rom_ok;
                if (ASn) begin
                    // CPU abandoned the cycle: drop everything silently
                    st_nx     = IDLE;
                    dtackn_nx = 1'b1;
                    wcnt_nx   = '0;
                    tcnt_nx   = '0;
                    ok_l_nx   = 1'b0;
                end else if (dog_c) begin
                    st_nx     = ACK;
                    dtackn_nx = 1'b0;
                    tout_nx   = 1'b1;
                end else if (ack_c) begin
                    st_nx     = ACK;
                    dtackn_nx = 1'b0;
                end else if (cen && (st == WAIT_FIX)) begin
                    wcnt_nx = wcnt - WCW'(1);
                end
            end

            ACK: begin
                dtackn_nx = 1'b0;
                wcnt_nx   = '0;
                if (ASn) begin
                    st_nx     = IDLE;
                    dtackn_nx = 1'b1;
                end
            end

            default: begin
                st_nx     = IDLE;
                dtackn_nx = 1'b1;
                wcnt_nx   = '0;
            end
        endcase

        busy_nx = (st_nx == WAIT_FIX) || (st_nx == WAIT_ROM) || (st_nx == WAIT_HUC);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            wcnt     <= '0;
            tcnt     <= '0;
            ok_l     <= 1'b0;
            DTACKn   <= 1'b1;
            busy     <= 1'b0;
            tout     <= 1'b0;
            unmapped <= 1'b0;
        end else begin
            st       <= st_nx;
            wcnt     <= wcnt_nx;
            tcnt     <= tcnt_nx;
            ok_l     <= ok_l_nx;
            DTACKn   <= dtackn_nx;
            busy     <= busy_nx;
            tout     <= tout_nx;
            unmapped <= unmapped_nx;
        end
    end

endmodule

// File: tb/tb_jtcop_bus_resp.sv
// Directed bench for jtcop_bus_resp with default parameters
// (RAM_WAIT=0, IO_WAIT=1, TOUT=255). cen pulses on every 4th clk edge.
module tb_jtcop_bus_resp;

    logic clk = 1'b0;
    logic rst, cen, ASn, UDSn, LDSn;
    logic rom_cs, rom_ok, ram_cs, io_cs, huc_cs, huc_ack;
    logic DTACKn, busy, tout, unmapped;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    jtcop_bus_resp dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .ASn      (ASn),
        .UDSn     (UDSn),
        .LDSn     (LDSn),
        .rom_cs   (rom_cs),
        .rom_ok   (rom_ok),
        .ram_cs   (ram_cs),
        .io_cs    (io_cs),
        .huc_cs   (huc_cs),
        .huc_ack  (huc_ack),
        .DTACKn   (DTACKn),
        .busy     (busy),
        .tout     (tout),
        .unmapped (unmapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clk edge; cen is prepared for the following edge (every 4th edge)
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        cen = ((cyc + 1) % 4 == 0);
    endtask

    // Advance until the next edge carries cen
    task automatic to_cen();
        for (int i = 0; i < 8 && !cen; i++) step();
    endtask

    task automatic release_bus();
        ASn = 1'b1; UDSn = 1'b1; LDSn = 1'b1;
        rom_cs = 1'b0; ram_cs = 1'b0; io_cs = 1'b0; huc_cs = 1'b0;
        rom_ok = 1'b0; huc_ack = 1'b0;
    endtask

    initial begin
        int n;
        int tcount, tat, dat;
        logic ok;

        cen = 1'b0;
        rst = 1'b1;
        release_bus();
        for (int i = 0; i < 3; i++) step();
        chk("rst_dtackn",   32'(DTACKn),   32'd1);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_tout",     32'(tout),     32'd0);
        chk("rst_unmapped", 32'(unmapped), 32'd0);
        rst = 1'b0;
        step();

        // RAM read, zero wait: ack on the cen after the start cen
        to_cen();
        ASn = 1'b0; LDSn = 1'b0; ram_cs = 1'b1;
        step();
        chk("ram_busy_start", 32'(busy),   32'd1);
        chk("ram_dtack_start", 32'(DTACKn), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (DTACKn !== 1'b1) ok = 1'b0;
        end
        chk("ram_no_early_ack", 32'(ok), 32'd1);
        step();
        chk("ram_dtack", 32'(DTACKn), 32'd0);
        chk("ram_busy_ack", 32'(busy), 32'd0);
        release_bus();
        step();
        chk("ram_release", 32'(DTACKn), 32'd1);

        // IO write, one wait: ack on second cen; early UDSn release ignored
        to_cen();
        ASn = 1'b0; UDSn = 1'b0; io_cs = 1'b1;
        step();
        chk("io_busy_start", 32'(busy), 32'd1);
        UDSn = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (DTACKn !== 1'b1 || unmapped !== 1'b0) ok = 1'b0;
        end
        chk("io_no_early_ack", 32'(ok), 32'd1);
        step();
        chk("io_dtack", 32'(DTACKn), 32'd0);
        release_bus();
        step();
        chk("io_release", 32'(DTACKn), 32'd1);

        // ROM with a stale rom_ok pulse right after start
        to_cen();
        ASn = 1'b0; LDSn = 1'b0; rom_cs = 1'b1;
        step();
        rom_ok = 1'b1;
        step();
        rom_ok = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (DTACKn !== 1'b1) ok = 1'b0;
        end
        chk("rom_stale_rejected", 32'(ok), 32'd1);
        rom_ok = 1'b1;
        n = 0;
        while (DTACKn === 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("rom_ack_latency", 32'(n), 32'd3);
        release_bus();
        step();
        chk("rom_release", 32'(DTACKn), 32'd1);

        // ROM beats RAM at start; dropping selects mid-cycle changes nothing
        to_cen();
        ASn = 1'b0; LDSn = 1'b0; rom_cs = 1'b1; ram_cs = 1'b1;
        step();
        rom_cs = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (DTACKn !== 1'b1 || busy !== 1'b1) ok = 1'b0;
        end
        chk("prio_waits_rom", 32'(ok), 32'd1);
        rom_ok = 1'b1;
        n = 0;
        while (DTACKn === 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("prio_rom_latency", 32'(n), 32'd2);
        release_bus();
        step();

        // HuC granted two clks into the cycle: ack at the next cen
        to_cen();
        ASn = 1'b0; LDSn = 1'b0; huc_cs = 1'b1;
        step();
        step();
        huc_ack = 1'b1;
        n = 0;
        while (DTACKn === 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("huc_ack_latency", 32'(n), 32'd3);
        release_bus();
        step();

        // HuC starvation: watchdog at the 255th clk, single tout pulse
        to_cen();
        ASn = 1'b0; UDSn = 1'b0; huc_cs = 1'b1;
        step();
        tcount = 0; tat = 0; dat = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (tout === 1'b1) begin
                tcount++;
                tat = k;
            end
            if (DTACKn === 1'b0 && dat == 0) dat = k;
        end
        chk("dog_pulses",  32'(tcount), 32'd1);
        chk("dog_tout_at", 32'(tat),    32'd255);
        chk("dog_ack_at",  32'(dat),    32'd255);
        chk("dog_hold",    32'(DTACKn), 32'd0);
        chk("dog_busy",    32'(busy),   32'd0);
        release_bus();
        step();
        chk("dog_release", 32'(DTACKn), 32'd1);

        // Abort from a wait state: no ack, no later tout
        to_cen();
        ASn = 1'b0; LDSn = 1'b0; huc_cs = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        release_bus();
        step();
        chk("abort_dtackn", 32'(DTACKn), 32'd1);
        chk("abort_busy",   32'(busy),   32'd0);
        tcount = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (tout === 1'b1 || DTACKn !== 1'b1) tcount++;
        end
        chk("abort_quiet", 32'(tcount), 32'd0);

        // Unmapped access: one-clk flag, ack after IO wait
        to_cen();
        ASn = 1'b0; LDSn = 1'b0;
        step();
        chk("unm_pulse", 32'(unmapped), 32'd1);
        chk("unm_busy",  32'(busy),     32'd1);
        step();
        chk("unm_pulse_end", 32'(unmapped), 32'd0);
        n = 1;
        while (DTACKn === 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("unm_ack_latency", 32'(n), 32'd8);
        release_bus();
        step();

        // Reset mid WAIT_FIX, then a held ASn restarts from IDLE at next cen
        to_cen();
        ASn = 1'b0; LDSn = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        chk("mrst_dtackn",   32'(DTACKn),   32'd1);
        chk("mrst_busy",     32'(busy),     32'd0);
        chk("mrst_unmapped", 32'(unmapped), 32'd0);
        rst = 1'b0;
        to_cen();
        step();
        chk("mrst_restart", 32'(unmapped), 32'd1);
        release_bus();
        step();
        chk("mrst_final", 32'(DTACKn), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
